gpio_mulpop_acc: RTL and testbench

Bus-mapped multiply-and-popcount coprocessor for the GPIO emulator address space. Software writes two operands and a start command; the block runs an iterative shift-add multiply of STEP bits per clock, then counts the ones in the result. Status, result and ones-count are read back over the same strobe bus. This is the parametrised successor of the fixed 24x24 unit: width, throughput and base address are configurable, and the bus, overflow and error handling are fully synchronous.

---
 rtl/gpio_mulpop_pkg.sv | 32 +++
 rtl/gpio_mulpop_acc_if.sv | 13 +
 rtl/gpio_seq_mult.sv | 72 +++++++
 rtl/gpio_mulpop_acc.sv | 143 ++++++++++++++
 tb/tb_gpio_mulpop_acc.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/gpio_mulpop_pkg.sv
// Shared types, register offsets and status bit positions for the
// multiply-and-popcount coprocessor.
package gpio_mulpop_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned BUS_W  = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MULT  = 2'd1,
    COUNT = 2'd2
  } state_e;

  localparam int unsigned OFF_A1  = 32'h00;
  localparam int unsigned OFF_A2  = 32'h08;
  localparam int unsigned OFF_W   = 32'h10;
  localparam int unsigned OFF_L   = 32'h18;
  localparam int unsigned OFF_CSR = 32'h20;

  localparam int unsigned ST_VALID = 0;
  localparam int unsigned ST_READY = 1;
  localparam int unsigned ST_BUSY  = 2;
  localparam int unsigned ST_ERR   = 3;

  function automatic logic [5:0] popcount32(input logic [31:0] v);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) n = n + 6'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/gpio_mulpop_acc_if.sv
// Strobe bus between the GPIO emulator master and the coprocessor.
interface gpio_mulpop_acc_if;
  import gpio_mulpop_pkg::*;

  logic [ADDR_W-1:0] saddress;
  logic              srd;
  logic              swr;
  logic [BUS_W-1:0]  sdata_in;
  logic [BUS_W-1:0]  sdata_out;

  modport master (output saddress, output srd, output swr, output sdata_in, input sdata_out);
  modport slave  (input saddress, input srd, input swr, input sdata_in, output sdata_out);
endinterface

// File: rtl/gpio_seq_mult.sv
// Iterative shift-add multiplier consuming STEP multiplier bits per clock;
// the full 2*OP_W product is kept.
module gpio_seq_mult #(
  parameter int unsigned OP_W = 24,
  parameter int unsigned STEP = 1
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              start_i,
  input  logic [OP_W-1:0]   a_i,
  input  logic [OP_W-1:0]   b_i,
  output logic [2*OP_W-1:0] product_o,
  output logic              done_c
);
  localparam int unsigned PROD_W = 2 * OP_W;
  localparam int unsigned M      = OP_W / STEP;
  localparam int unsigned CW     = (M > 1) ? $clog2(M) : 1;

  if ((STEP < 1) || (STEP > OP_W) || ((OP_W % STEP) != 0)) begin : g_bad_step
    $error("gpio_seq_mult: STEP must divide OP_W");
  end

  logic [PROD_W-1:0] mcand_q, mcand_d, acc_q, acc_d, addend;
  logic [OP_W-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              run_q, run_d;

  // High while the final partial product is being accumulated.
  assign done_c    = run_q && (cnt_q == CW'(M - 1));
  assign product_o = acc_q;

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    run_d    = run_q;
    addend   = '0;
    for (int j = 0; j < int'(STEP); j++) begin
      if (mplier_q[j]) addend = addend + (mcand_q << j);
    end
    if (start_i) begin
      mcand_d  = PROD_W'(a_i);
      mplier_d = b_i;
      acc_d    = '0;
      cnt_d    = '0;
      run_d    = 1'b1;
    end else if (run_q) begin
      acc_d    = acc_q + addend;
      mcand_d  = mcand_q << STEP;
      mplier_d = mplier_q >> STEP;
      cnt_d    = cnt_q + CW'(1);
      if (done_c) run_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      run_q    <= run_d;
    end
  end
endmodule

// File: rtl/gpio_mulpop_acc.sv
// Bus-mapped multiply-and-popcount coprocessor: register window, control FSM,
// result commit and operation counter around the sequential multiplier.
module gpio_mulpop_acc
  import gpio_mulpop_pkg::*;
#(
  parameter int unsigned OP_W      = 24,
  parameter int unsigned RES_W     = 32,
  parameter int unsigned STEP      = 1,
  parameter logic [15:0] BASE_ADDR = 16'h0380,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                clk,
  input  logic                n_reset,
  gpio_mulpop_acc_if.slave    bus,
  output logic [31:0]         gpio_out,
  output logic                done_irq
);
  localparam int unsigned PROD_W = 2 * OP_W;
  localparam int unsigned L_W    = $clog2(RES_W + 1);

  state_e              state_q, state_d;
  logic [OP_W-1:0]     a1_q, a1_d, a2_q, a2_d;
  logic [RES_W-1:0]    w_q, w_d, w_next;
  logic [L_W-1:0]      l_q, l_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BUS_W-1:0]    rdata_q, rdata_d, status;
  logic                valid_q, valid_d, err_q, err_d, irq_q, irq_d;
  logic                mult_start, mult_done_c, hi_zero;
  logic [PROD_W-1:0]   prod;
  logic                sel_a1, sel_a2, sel_w, sel_l, sel_csr;

  gpio_seq_mult #(.OP_W(OP_W), .STEP(STEP)) u_mult (
    .clk       (clk),
    .n_reset   (n_reset),
    .start_i   (mult_start),
    .a_i       (a1_q),
    .b_i       (a2_q),
    .product_o (prod),
    .done_c    (mult_done_c)
  );

  // Result is valid only when nothing above RES_W was lost in truncation.
  if (PROD_W > RES_W) begin : g_trunc
    assign hi_zero = ~|prod[PROD_W-1:RES_W];
  end else begin : g_fits
    assign hi_zero = 1'b1;
  end
  assign w_next = RES_W'(prod);

  assign sel_a1  = bus.saddress == 16'(BASE_ADDR + OFF_A1);
  assign sel_a2  = bus.saddress == 16'(BASE_ADDR + OFF_A2);
  assign sel_w   = bus.saddress == 16'(BASE_ADDR + OFF_W);
  assign sel_l   = bus.saddress == 16'(BASE_ADDR + OFF_L);
  assign sel_csr = bus.saddress == 16'(BASE_ADDR + OFF_CSR);

  always_comb begin
    status           = '0;
    status[ST_VALID] = valid_q;
    status[ST_READY] = (state_q == IDLE);
    status[ST_BUSY]  = (state_q != IDLE);
    status[ST_ERR]   = err_q;
  end

  always_comb begin
    state_d    = state_q;
    a1_d       = a1_q;
    a2_d       = a2_q;
    w_d        = w_q;
    l_d        = l_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    valid_d    = valid_q;
    err_d      = err_q;
    irq_d      = 1'b0;
    mult_start = 1'b0;

    // Reads see pre-edge state; a status read clears err unless a write re-sets it.
    if (bus.srd) begin
      rdata_d = '0;
      if (sel_a1) rdata_d = 32'(a1_q);
      if (sel_a2) rdata_d = 32'(a2_q);
      if (sel_w)  rdata_d = 32'(w_q);
      if (sel_l)  rdata_d = 32'(l_q);
      if (sel_csr) begin
        rdata_d = status;
        err_d   = 1'b0;
      end
    end

    if (bus.swr) begin
      if (sel_a1) a1_d = bus.sdata_in[OP_W-1:0];
      if (sel_a2) a2_d = bus.sdata_in[OP_W-1:0];
      if (sel_csr) begin
        if (state_q == IDLE) mult_start = 1'b1;
        else                 err_d      = 1'b1;
      end
    end

    case (state_q)
      IDLE:  if (mult_start) state_d = MULT;
      MULT:  if (mult_done_c) state_d = COUNT;
      COUNT: begin
        w_d     = w_next;
        l_d     = L_W'(popcount32(32'(w_next)));
        valid_d = hi_zero;
        cnt_d   = cnt_q + CNT_W'(1);
        irq_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= IDLE;
      a1_q    <= '0;
      a2_q    <= '0;
      w_q     <= '0;
      l_q     <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      valid_q <= 1'b1;
      err_q   <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a1_q    <= a1_d;
      a2_q    <= a2_d;
      w_q     <= w_d;
      l_q     <= l_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      irq_q   <= irq_d;
    end
  end

  assign bus.sdata_out = rdata_q;
  assign gpio_out      = 32'(cnt_q);
  assign done_irq      = irq_q;
endmodule

// File: tb/tb_gpio_mulpop_acc.sv
// Randomized and directed bench for gpio_mulpop_acc: a 24x24 STEP=1 instance
// and a STEP=4, CNT_W=4 instance checked against an arithmetic model.
module tb_gpio_mulpop_acc;
  localparam logic [15:0] A_A1  = 16'h0380;
  localparam logic [15:0] A_A2  = 16'h0388;
  localparam logic [15:0] A_W   = 16'h0390;
  localparam logic [15:0] A_L   = 16'h0398;
  localparam logic [15:0] A_CSR = 16'h03A0;

  logic clk = 1'b0;
  logic n_reset = 1'b0;
  always #5 clk = ~clk;

  gpio_mulpop_acc_if bus0();
  gpio_mulpop_acc_if bus1();
  logic [31:0] gpio0, gpio1;
  logic        irq0, irq1;

  gpio_mulpop_acc u_dut0 (
    .clk(clk), .n_reset(n_reset), .bus(bus0), .gpio_out(gpio0), .done_irq(irq0)
  );
  gpio_mulpop_acc #(.STEP(4), .CNT_W(4)) u_dut1 (
    .clk(clk), .n_reset(n_reset), .bus(bus1), .gpio_out(gpio1), .done_irq(irq1)
  );

  int checks = 0;
  int failures = 0;
  int irq_n0 = 0;
  int irq_n1 = 0;

  // Reference state per instance
  logic [31:0] exp_w[2];
  logic [31:0] exp_l[2];
  logic        exp_valid[2];
  int          exp_cnt[2];
  int          exp_irq[2];

  always @(negedge clk) begin
    if (irq0) irq_n0++;
    if (irq1) irq_n1++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input int d, input logic rd, input logic wr,
                       input logic [15:0] a, input logic [31:0] wd);
    if (d == 0) begin
      bus0.srd = rd; bus0.swr = wr; bus0.saddress = a; bus0.sdata_in = wd;
    end else begin
      bus1.srd = rd; bus1.swr = wr; bus1.saddress = a; bus1.sdata_in = wd;
    end
  endtask

  // One bus cycle starting and ending on a falling edge.
  task automatic xfer(input int d, input logic rd, input logic wr, input logic [15:0] a,
                      input logic [31:0] wd, output logic [31:0] rdat);
    drive(d, rd, wr, a, wd);
    @(negedge clk);
    drive(d, 1'b0, 1'b0, 16'h0, 32'h0);
    rdat = (d == 0) ? bus0.sdata_out : bus1.sdata_out;
  endtask

  task automatic bwr(input int d, input logic [15:0] a, input logic [31:0] wd);
    logic [31:0] junk;
    xfer(d, 1'b0, 1'b1, a, wd, junk);
  endtask

  task automatic brd(input int d, input logic [15:0] a, output logic [31:0] rdat);
    xfer(d, 1'b1, 1'b0, a, 32'h0, rdat);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [23:0] rand24();
    case ($urandom_range(0, 2))
      0:       return 24'($urandom_range(0, 255));
      1:       return 24'hFFFFFF - 24'($urandom_range(0, 15));
      default: return 24'($urandom);
    endcase
  endfunction

  function automatic int steps(input int d);
    return (d == 0) ? 24 : 6;
  endfunction

  function automatic logic [31:0] cnt_mask(input int d);
    return (d == 0) ? 32'h0000FFFF : 32'h0000000F;
  endfunction

  task automatic model_op(input int d, input logic [23:0] a, input logic [23:0] b);
    logic [63:0] p;
    p = 64'(a) * 64'(b);
    exp_w[d]     = p[31:0];
    exp_l[d]     = 32'($countones(p[31:0]));
    exp_valid[d] = (p[63:32] == 32'h0);
    exp_cnt[d]   = exp_cnt[d] + 1;
    exp_irq[d]   = exp_irq[d] + 1;
  endtask

  task automatic poll_ready(input int d, output int busy);
    logic [31:0] r;
    bit ok;
    ok = 0;
    busy = 0;
    for (int i = 0; i < 200; i++) begin
      brd(d, A_CSR, r);
      if (r[1]) begin ok = 1; break; end
      busy++;
    end
    if (!ok) check_eq("ready_timeout", 32'(busy), 32'(0));
  endtask

  task automatic check_result(input int d);
    logic [31:0] r;
    brd(d, A_W, r);
    check_eq("result_w", r, exp_w[d]);
    brd(d, A_L, r);
    check_eq("result_l", r, exp_l[d]);
    brd(d, A_CSR, r);
    check_eq("status", r, {28'h0, 1'b0, 1'b0, 1'b1, exp_valid[d]});
    check_eq("irq_count", 32'((d == 0) ? irq_n0 : irq_n1), 32'(exp_irq[d]));
    check_eq("gpio_out", (d == 0) ? gpio0 : gpio1, 32'(exp_cnt[d]) & cnt_mask(d));
  endtask

  task automatic run_op(input int d, input logic [23:0] a, input logic [23:0] b);
    int busy;
    bwr(d, A_A1, 32'(a));
    bwr(d, A_A2, 32'(b));
    bwr(d, A_CSR, 32'h0);
    poll_ready(d, busy);
    check_eq("busy_cycles", 32'(busy), 32'(steps(d) + 1));
    model_op(d, a, b);
    check_result(d);
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      exp_w[d] = 32'h0; exp_l[d] = 32'h0; exp_valid[d] = 1'b1; exp_cnt[d] = 0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    logic [23:0] a, b, na, nb;
    int busy;

    drive(0, 1'b0, 1'b0, 16'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 16'h0, 32'h0);
    exp_irq[0] = 0; exp_irq[1] = 0;
    model_reset();
    idle(2);
    n_reset = 1'b1;
    idle(1);

    // Reset values
    check_eq("rst_done_irq", 32'(irq0), 32'h0);
    check_result(0);
    check_result(1);

    // Directed, 24x24 STEP=1
    run_op(0, 24'd3, 24'd5);
    run_op(0, 24'hFFFFFF, 24'hFFFFFF);

    // Second start three cycles after the first: ignored, err set
    a = rand24(); b = rand24();
    bwr(0, A_A1, 32'(a));
    bwr(0, A_A2, 32'(b));
    bwr(0, A_CSR, 32'h0);
    idle(2);
    bwr(0, A_CSR, 32'h0);
    brd(0, A_CSR, r);
    check_eq("err_busy_status", r, {28'h0, 1'b1, 1'b1, 1'b0, exp_valid[0]});
    brd(0, A_CSR, r);
    check_eq("err_cleared", r, {28'h0, 1'b0, 1'b1, 1'b0, exp_valid[0]});
    poll_ready(0, busy);
    model_op(0, a, b);
    check_result(0);

    // Start landing on the commit edge is still treated as busy
    a = rand24(); b = rand24();
    bwr(0, A_A1, 32'(a));
    bwr(0, A_A2, 32'(b));
    bwr(0, A_CSR, 32'h0);
    idle(steps(0));
    bwr(0, A_CSR, 32'h0);
    model_op(0, a, b);
    brd(0, A_CSR, r);
    check_eq("err_commit_edge", r, {28'h0, 1'b1, 1'b0, 1'b1, exp_valid[0]});
    idle(40);
    check_result(0);

    for (int i = 0; i < 6; i++) run_op(0, rand24(), rand24());

    // STEP=4 instance
    run_op(1, 24'h123456, 24'h000010);
    na = rand24(); nb = rand24();
    bwr(1, A_A1, 32'h123456);
    bwr(1, A_A2, 32'h10);
    bwr(1, A_CSR, 32'h0);
    bwr(1, A_A1, 32'(na));
    bwr(1, A_A2, 32'(nb));
    poll_ready(1, busy);
    model_op(1, 24'h123456, 24'h000010);
    check_result(1);
    bwr(1, A_CSR, 32'h0);
    poll_ready(1, busy);
    check_eq("busy_cycles_next", 32'(busy), 32'(steps(1) + 1));
    model_op(1, na, nb);
    check_result(1);
    for (int i = 0; i < 6; i++) run_op(1, rand24(), rand24());

    // Reset ten cycles into a multiply: abort, no commit
    bwr(0, A_A1, 32'(rand24()));
    bwr(0, A_A2, 32'(rand24()));
    bwr(0, A_CSR, 32'h0);
    idle(10);
    n_reset = 1'b0;
    model_reset();
    idle(2);
    n_reset = 1'b1;
    idle(40);
    check_result(0);
    check_result(1);
    brd(0, A_A1, r);
    check_eq("rst_a1", r, 32'h0);

    // Counter wrap on the 4-bit instance
    for (int i = 0; i < 17; i++) run_op(1, rand24(), rand24());
    check_eq("gpio_wrap", gpio1, 32'h1);

    // Register window edges
    bwr(0, A_A1, 32'hFFABCDEF);
    brd(0, A_A1, r);
    check_eq("a1_mask", r, 32'h00ABCDEF);
    brd(0, 16'h03A8, r);
    check_eq("unmapped_rd", r, 32'h0);
    bwr(0, 16'h0384, 32'h00111111);
    brd(0, A_A1, r);
    check_eq("unmapped_wr", r, 32'h00ABCDEF);
    xfer(0, 1'b1, 1'b1, A_A1, 32'h00000123, r);
    check_eq("rdwr_old", r, 32'h00ABCDEF);
    brd(0, A_A1, r);
    check_eq("rdwr_new", r, 32'h00000123);
    bwr(0, A_W, 32'hDEADBEEF);
    brd(0, A_W, r);
    check_eq("w_readonly", r, exp_w[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
